// File: rtl/posit_accumulator_8bit.sv
// Streaming posit<8,0> packet accumulator built around a combinational posit adder.
// Optional sticky NaR output flag: define POSIT_ACC_NAR_FLAG_EN.

module posit_adder_8bit (
  input  logic [7:0] lhs,
  input  logic [7:0] rhs,
  output logic [7:0] add_result
);
  // Every posit<8,0> is an integer multiple of 2^-6 no larger than 2^6, so
  // a 13-bit fixed-point magnitude with 6 fraction bits holds any operand exactly.
  function automatic logic [12:0] decode_mag(input logic [7:0] p);
    logic [6:0]  body;
    logic [6:0]  sh;
    logic [12:0] sig;
    logic        r0;
    logic        stop;
    int          run;
    int          k;
    body = p[7] ? (~p[6:0] + 7'd1) : p[6:0];
    r0   = body[6];
    run  = 0;
    stop = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!stop && body[i] == r0) run++;
      else stop = 1'b1;
    end
    k   = r0 ? run - 1 : -run;
    sh  = body << (run + 1);
    sig = 13'd64 | (13'(sh) >> 1);
    decode_mag = (k >= 0) ? (sig << k) : (sig >> (-k));
  endfunction

  // Round the exact sum to nearest-even on the posit bit pattern, saturating at maxpos.
  function automatic logic [7:0] encode(input logic neg, input logic [13:0] mag);
    logic [27:0] rg;
    logic [27:0] fr;
    logic [27:0] ext;
    logic [6:0]  body;
    int          p;
    int          k;
    int          rlen;
    p = 0;
    for (int i = 0; i < 14; i++) if (mag[i]) p = i;
    k = p - 6;
    if (k >= 6) begin
      body = 7'h7F;
    end else begin
      if (k >= 0) begin
        rg   = ~(28'hFFF_FFFF >> (k + 1));
        rlen = k + 2;
      end else begin
        rg   = 28'h800_0000 >> (-k);
        rlen = 1 - k;
      end
      fr   = {mag, 14'd0} << (14 - p);
      ext  = rg | (fr >> rlen);
      body = ext[27:21];
      if (ext[20] && ((|ext[19:0]) || body[0])) body = body + 7'd1;
    end
    if (mag == 14'd0) encode = 8'h00;
    else              encode = neg ? (~{1'b0, body} + 8'd1) : {1'b0, body};
  endfunction

  logic signed [14:0] sa, sb, s;
  logic        [13:0] m;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    add_result = 8'h00;
    sa = {2'b00, decode_mag(lhs)};
    sb = {2'b00, decode_mag(rhs)};
    if (lhs[7]) sa = -sa;
    if (rhs[7]) sb = -sb;
    s = sa + sb;
    m = s[14] ? (~s[13:0] + 14'd1) : s[13:0];
    if (lhs == 8'h80 || rhs == 8'h80) add_result = 8'h80;
    else if (lhs == 8'h00)            add_result = rhs;
    else if (rhs == 8'h00)            add_result = lhs;
    else                              add_result = encode(s[14], m);
  end
endmodule

module posit_accumulator_8bit #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
`ifdef POSIT_ACC_NAR_FLAG_EN
  output logic                   out_nar,
`endif
  output logic [COUNT_WIDTH-1:0] out_count
);
  typedef enum logic {ACCUM, DONE} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [7:0]             add_result;
  logic                   beat;

  posit_adder_8bit u_adder (
    .lhs        (acc_q),
    .rhs        (in_data),
    .add_result (add_result)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign beat      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (flush) begin
      state_d = ACCUM;
      acc_d   = 8'h00;
      count_d = '0;
    end else begin
      case (state_q)
        ACCUM: if (beat) begin
          acc_d   = add_result;
          count_d = (&count_q) ? count_q : count_q + 1'b1;
          if (in_last) state_d = DONE;
        end
        DONE: if (out_ready) begin
          state_d = ACCUM;
          acc_d   = 8'h00;
          count_d = '0;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= 8'h00;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

`ifdef POSIT_ACC_NAR_FLAG_EN
  logic nar_q, nar_d;

  always_comb begin
    nar_d = nar_q;
    if (flush || (out_valid && out_ready)) nar_d = 1'b0;
    else if (beat && in_data == 8'h80)     nar_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) nar_q <= 1'b0;
    else     nar_q <= nar_d;
  end

  assign out_nar = nar_q;
`endif
endmodule

// File: doc/posit_accumulator_8bit.md
Name: posit_accumulator_8bit

Overview:
- Sequential streaming accumulator that sits directly downstream of posit_adder_8bit.
- Consumes a packetised stream of 8-bit posits (es=0) over a valid/ready handshake.
- Feeds the running sum and each accepted operand into one combinational posit_adder_8bit instance, and registers the adder's add_result back as the running sum.
- Emits the packet total on a valid/ready output port, giving dot-product and reduction datapaths a one-beat-per-cycle sum engine.

Parameters:
- COUNT_WIDTH, 8, width of the beat counter. The counter saturates at 2^COUNT_WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous abort; discards the partial sum and any pending result
- in_valid  input  1  operand beat valid
- in_ready  output  1  accumulator can accept a beat
- in_data  input  8  operand posit
- in_last  input  1  marks the final beat of a packet
- out_valid  output  1  packet sum available
- out_ready  input  1  downstream accepts the sum
- out_data  output  8  packet sum posit
- out_count  output  COUNT_WIDTH  number of beats summed into out_data

Behaviour:
- Reset: synchronous, active-high.
  - When rst is high at a clock edge: state<=ACCUM, acc<=8'h00, count<=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=8'h00, out_count=0.
- Priority at each edge: rst > flush > handshakes.
- flush in either state: acc<=0, count<=0, state<=ACCUM. A pending result is dropped and not presented. Any beat offered in the same cycle is discarded.
- Internal adder: one posit_adder_8bit instance, lhs=acc, rhs=in_data. Purely combinational, with no extra pipeline stage.
- States:
  - ACCUM: in_ready=1, out_valid=0.
    - On in_valid&in_ready: acc<=add_result, count<=sat(count+1).
    - If in_last is also set, state<=DONE.
  - DONE: in_ready=0, out_valid=1, out_data=acc, out_count=count.
    - On out_ready: acc<=0, count<=0, state<=ACCUM.
- Latency: last beat accepted at edge N, out_valid=1 from cycle N+1.
- Throughput: 1 beat/cycle within a packet. Minimum one bubble cycle per packet, because in_ready=0 while in DONE.
- First beat: the first beat of every packet adds to acc=0. The adder's zero passthrough returns in_data unchanged (0+x=x).
- Single-beat packet: a beat with in_last=1 on an empty accumulator yields out_data=in_data and out_count=1.
- Output holds: out_data and out_count hold stable while out_valid=1 and out_ready=0.
- NaR (8'h80): the adder propagates NaR. Once any beat is 8'h80, acc stays 8'h80 until the packet ends. No special-case logic is needed here.
- Saturation: overflow and underflow saturation to maxpos/minpos is the adder's responsibility. The accumulator stores whatever add_result returns.
- Count: count+1 saturates at all-ones and does not wrap.
- Ignored inputs: in_last is ignored when in_valid=0. in_data and in_last are don't-care while in_ready=0.
- Reset mid-packet: the partial sum is lost and no output is produced.

Optional Feature:
- Macro: POSIT_ACC_NAR_FLAG_EN.
- When defined:
  - Adds output port out_nar (1 bit), a sticky flag set when any accepted beat of the current packet equals 8'h80.
  - out_nar is valid alongside out_data.
  - It is cleared by rst, by flush, and by an out handshake.
  - Reset value is 0.
- When undefined: the port and its flop do not exist, and behaviour is otherwise identical.

Test Plan:
- Beats 8'h40 then 8'h40 with last -> out_valid the cycle after the last beat, out_data=8'h60 (2.0), out_count=2.
- Beats 8'h40, 8'h20 with last -> out_data=8'h50 (1.5), out_count=2. With out_ready=0 for 3 cycles: out_data holds, in_ready=0, and extra in_valid beats are not consumed.
- Beats 8'h40, 8'hC0 (-1.0) with last -> out_data=8'h00, out_count=2. The next packet, single beat 8'h30 with last -> out_data=8'h30, out_count=1, proving acc was cleared.
- Beats 8'h40, 8'h80, 8'h20 with last -> out_data=8'h80. With POSIT_ACC_NAR_FLAG_EN defined, out_nar=1; on the following clean packet, out_nar=0.
- Beats 8'h7F, 8'h7F with last -> out_data=8'h7F (maxpos), out_count=2. With COUNT_WIDTH=2, a 5-beat packet of 8'h00 gives out_count=3 (saturated).
- Two beats accepted, then flush=1 in the same cycle as a third valid beat -> that beat is discarded, no out_valid is produced, and a following single beat 8'h40 with last gives 8'h40 with count 1. Repeat with rst instead of flush: same result.
